// File: rtl/issue_queue_pkg.sv
// Shared types and constants for the dual-issue queue.
// Uop type field, regmask bit positions and the queued entry layout.
package issue_queue_pkg;

    localparam int WIDTH_UOP   = 8;
    localparam int UOP_TYPE_LO = 0;
    localparam int UOP_TYPE_HI = 2;
    localparam int ISSUE_DEPTH = 8;

    localparam logic [2:0] ITYPE_IDX_ALU = 3'd0;

    localparam int REGMASK_USE_RJ = 0;
    localparam int REGMASK_USE_RK = 1;
    localparam int REGMASK_WR_RD  = 2;

    typedef struct packed {
        logic [WIDTH_UOP-1:0] uop;
        logic [4:0]           rd;
        logic [4:0]           rj;
        logic [4:0]           rk;
        logic [31:0]          pc;
        logic [31:0]          pc_next;
        logic [31:0]          imm;
        logic [5:0]           exp;
        logic [2:0]           regmask;
    } iq_entry_t;

    function automatic logic is_alu(input logic [WIDTH_UOP-1:0] u);
        return u[UOP_TYPE_HI:UOP_TYPE_LO] == ITYPE_IDX_ALU;
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decode-side enqueue, write-back snoop and issue bundle signals.
// master drives decode/control inputs; slave is the queue itself.
interface issue_queue_if;
    import issue_queue_pkg::*;

    logic                 flush;
    logic                 stall;
    logic                 in_ready;

    logic                 in0_valid;
    logic [WIDTH_UOP-1:0] in0_uop;
    logic [4:0]           in0_rd, in0_rj, in0_rk;
    logic [31:0]          in0_pc, in0_pc_next, in0_imm;
    logic [5:0]           in0_exp;
    logic [2:0]           in0_regmask;

    logic                 in1_valid;
    logic [WIDTH_UOP-1:0] in1_uop;
    logic [4:0]           in1_rd, in1_rj, in1_rk;
    logic [31:0]          in1_pc, in1_pc_next, in1_imm;
    logic [5:0]           in1_exp;
    logic [2:0]           in1_regmask;

    logic                 write_en_0, write_en_1;
    logic [4:0]           write_addr_0, write_addr_1;

    logic                 eu0_en_out;
    logic [WIDTH_UOP-1:0] eu0_uop_out;
    logic [4:0]           eu0_rd_out, eu0_rj_out, eu0_rk_out;
    logic [31:0]          eu0_pc_out, eu0_pc_next_out, eu0_imm_out;
    logic [5:0]           eu0_exp_out;

    logic                 eu1_en_out;
    logic [WIDTH_UOP-1:0] eu1_uop_out;
    logic [4:0]           eu1_rd_out, eu1_rj_out, eu1_rk_out;
    logic [31:0]          eu1_pc_out, eu1_pc_next_out, eu1_imm_out;
    logic [5:0]           eu1_exp_out;

    modport master (
        output flush, stall,
        output in0_valid, in0_uop, in0_rd, in0_rj, in0_rk,
        output in0_pc, in0_pc_next, in0_imm, in0_exp, in0_regmask,
        output in1_valid, in1_uop, in1_rd, in1_rj, in1_rk,
        output in1_pc, in1_pc_next, in1_imm, in1_exp, in1_regmask,
        output write_en_0, write_en_1, write_addr_0, write_addr_1,
        input  in_ready,
        input  eu0_en_out, eu0_uop_out, eu0_rd_out, eu0_rj_out,
        input  eu0_rk_out, eu0_pc_out, eu0_pc_next_out,
        input  eu0_imm_out, eu0_exp_out,
        input  eu1_en_out, eu1_uop_out, eu1_rd_out, eu1_rj_out,
        input  eu1_rk_out, eu1_pc_out, eu1_pc_next_out,
        input  eu1_imm_out, eu1_exp_out
    );

    modport slave (
        input  flush, stall,
        input  in0_valid, in0_uop, in0_rd, in0_rj, in0_rk,
        input  in0_pc, in0_pc_next, in0_imm, in0_exp, in0_regmask,
        input  in1_valid, in1_uop, in1_rd, in1_rj, in1_rk,
        input  in1_pc, in1_pc_next, in1_imm, in1_exp, in1_regmask,
        input  write_en_0, write_en_1, write_addr_0, write_addr_1,
        output in_ready,
        output eu0_en_out, eu0_uop_out, eu0_rd_out, eu0_rj_out,
        output eu0_rk_out, eu0_pc_out, eu0_pc_next_out,
        output eu0_imm_out, eu0_exp_out,
        output eu1_en_out, eu1_uop_out, eu1_rd_out, eu1_rj_out,
        output eu1_rk_out, eu1_pc_out, eu1_pc_next_out,
        output eu1_imm_out, eu1_exp_out
    );

endinterface

// File: rtl/issue_queue_scoreboard.sv
// 32-entry busy scoreboard with two set and two clear ports.
// busy_eff hides registers being written back this cycle (regfile bypass).
module issue_queue_scoreboard (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        set0_en,
    input  logic [4:0]  set0_addr,
    input  logic        set1_en,
    input  logic [4:0]  set1_addr,
    input  logic        clr0_en,
    input  logic [4:0]  clr0_addr,
    input  logic        clr1_en,
    input  logic [4:0]  clr1_addr,
    output logic [31:0] busy_eff
);

    logic [31:0] busy;
    logic [31:0] set_v;
    logic [31:0] clr_v;

    always_comb begin
        set_v = '0;
        clr_v = '0;
        if (set0_en) set_v[set0_addr] = 1'b1;
        if (set1_en) set_v[set1_addr] = 1'b1;
        if (clr0_en) clr_v[clr0_addr] = 1'b1;
        if (clr1_en) clr_v[clr1_addr] = 1'b1;
    end

    assign busy_eff = busy & ~clr_v;

    // A new producer outranks a stale write-back to the same register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_v) | set_v;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order dual-issue queue between decode and register-file read.
// eu0 takes any uop; eu1 takes a hazard-free ALU uop behind eu0.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = ISSUE_DEPTH
) (
    input logic          clk,
    input logic          rstn,
    issue_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;

    iq_entry_t   q [DEPTH];
    ptr_t        head, tail;
    logic [CW-1:0] count;
    logic [31:0] busy_eff;

    iq_entry_t   in0_e, in1_e, h0, h1;
    iq_entry_t   eu0_q, eu1_q;
    ptr_t        head_p1, tail_p1;
    logic        acc, iss0, iss1, dep;
    logic [1:0]  n_enq, n_iss;
    logic        eu0_en, eu1_en;

    function automatic logic rdy(input iq_entry_t e, input logic [31:0] b);
        return (!e.regmask[REGMASK_USE_RJ] || e.rj == 5'd0 || !b[e.rj]) &&
               (!e.regmask[REGMASK_USE_RK] || e.rk == 5'd0 || !b[e.rk]) &&
               (!e.regmask[REGMASK_WR_RD]  || e.rd == 5'd0 || !b[e.rd]);
    endfunction

    assign in0_e = '{uop: bus.in0_uop, rd: bus.in0_rd, rj: bus.in0_rj,
                     rk: bus.in0_rk, pc: bus.in0_pc,
                     pc_next: bus.in0_pc_next, imm: bus.in0_imm,
                     exp: bus.in0_exp, regmask: bus.in0_regmask};
    assign in1_e = '{uop: bus.in1_uop, rd: bus.in1_rd, rj: bus.in1_rj,
                     rk: bus.in1_rk, pc: bus.in1_pc,
                     pc_next: bus.in1_pc_next, imm: bus.in1_imm,
                     exp: bus.in1_exp, regmask: bus.in1_regmask};

    assign head_p1 = head + ptr_t'(1);
    assign tail_p1 = tail + ptr_t'(1);
    assign h0 = q[head];
    assign h1 = q[head_p1];

    assign bus.in_ready = (count <= CW'(DEPTH - 2));
    assign acc = bus.in_ready && !bus.flush && bus.in0_valid;

    always_comb begin
        n_enq = 2'd0;
        if (acc) n_enq = bus.in1_valid ? 2'd2 : 2'd1;
    end

    // head+1 must not touch the register head is about to produce.
    always_comb begin
        dep = 1'b0;
        if (h0.regmask[REGMASK_WR_RD] && h0.rd != 5'd0) begin
            dep = (h1.regmask[REGMASK_USE_RJ] && h1.rj == h0.rd) ||
                  (h1.regmask[REGMASK_USE_RK] && h1.rk == h0.rd) ||
                  (h1.regmask[REGMASK_WR_RD]  && h1.rd == h0.rd);
        end
    end

    assign iss0 = (count != '0) && rdy(h0, busy_eff) &&
                  !bus.stall && !bus.flush;
    assign iss1 = iss0 && (count >= CW'(2)) && rdy(h1, busy_eff) &&
                  is_alu(h1.uop) && !dep;
    assign n_iss = iss1 ? 2'd2 : (iss0 ? 2'd1 : 2'd0);

    issue_queue_scoreboard u_sb (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (bus.flush),
        .set0_en   (iss0 && h0.regmask[REGMASK_WR_RD] && h0.rd != 5'd0),
        .set0_addr (h0.rd),
        .set1_en   (iss1 && h1.regmask[REGMASK_WR_RD] && h1.rd != 5'd0),
        .set1_addr (h1.rd),
        .clr0_en   (bus.write_en_0),
        .clr0_addr (bus.write_addr_0),
        .clr1_en   (bus.write_en_1),
        .clr1_addr (bus.write_addr_1),
        .busy_eff  (busy_eff)
    );

    always_ff @(posedge clk) begin
        if (acc) begin
            q[tail] <= in0_e;
            if (bus.in1_valid) q[tail_p1] <= in1_e;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ptr_t'(n_iss);
            tail  <= tail + ptr_t'(n_enq);
            count <= count + CW'(n_enq) - CW'(n_iss);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eu0_en <= 1'b0;
            eu1_en <= 1'b0;
            eu0_q  <= '0;
            eu1_q  <= '0;
        end else begin
            eu0_en <= iss0;
            eu1_en <= iss1;
            if (iss0) eu0_q <= h0;
            if (iss1) eu1_q <= h1;
        end
    end

    assign bus.eu0_en_out      = eu0_en;
    assign bus.eu0_uop_out     = eu0_q.uop;
    assign bus.eu0_rd_out      = eu0_q.rd;
    assign bus.eu0_rj_out      = eu0_q.rj;
    assign bus.eu0_rk_out      = eu0_q.rk;
    assign bus.eu0_pc_out      = eu0_q.pc;
    assign bus.eu0_pc_next_out = eu0_q.pc_next;
    assign bus.eu0_imm_out     = eu0_q.imm;
    assign bus.eu0_exp_out     = eu0_q.exp;

    assign bus.eu1_en_out      = eu1_en;
    assign bus.eu1_uop_out     = eu1_q.uop;
    assign bus.eu1_rd_out      = eu1_q.rd;
    assign bus.eu1_rj_out      = eu1_q.rj;
    assign bus.eu1_rk_out      = eu1_q.rk;
    assign bus.eu1_pc_out      = eu1_q.pc;
    assign bus.eu1_pc_next_out = eu1_q.pc_next;
    assign bus.eu1_imm_out     = eu1_q.imm;
    assign bus.eu1_exp_out     = eu1_q.exp;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: pairing, hazards, fill/wrap, flush,
// asynchronous reset.
module tb_issue_queue;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    issue_queue_if bus();

    issue_queue dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    localparam logic [7:0] ALU = 8'h00;
    localparam logic [7:0] MEM = 8'h01;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int s, input logic [7:0] u,
                       input logic [4:0] rd, input logic [4:0] rj,
                       input logic [4:0] rk, input logic [2:0] m,
                       input logic [31:0] pc);
        if (s == 0) begin
            bus.in0_valid = 1'b1; bus.in0_uop = u;
            bus.in0_rd = rd; bus.in0_rj = rj; bus.in0_rk = rk;
            bus.in0_regmask = m; bus.in0_pc = pc;
            bus.in0_pc_next = pc + 32'd4; bus.in0_imm = pc ^ 32'h55;
            bus.in0_exp = pc[7:2];
        end else begin
            bus.in1_valid = 1'b1; bus.in1_uop = u;
            bus.in1_rd = rd; bus.in1_rj = rj; bus.in1_rk = rk;
            bus.in1_regmask = m; bus.in1_pc = pc;
            bus.in1_pc_next = pc + 32'd4; bus.in1_imm = pc ^ 32'h55;
            bus.in1_exp = pc[7:2];
        end
    endtask

    task automatic idle();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
    endtask

    task automatic wb(input logic e0, input logic [4:0] a0,
                      input logic e1, input logic [4:0] a1);
        bus.write_en_0 = e0; bus.write_addr_0 = a0;
        bus.write_en_1 = e1; bus.write_addr_1 = a1;
    endtask

    initial begin
        bus.flush = 0; bus.stall = 0;
        idle();
        put(0, ALU, 0, 0, 0, 0, 0);
        put(1, ALU, 0, 0, 0, 0, 0);
        idle();
        wb(0, 0, 0, 0);

        step();
        step();
        chk("rst_en0", bus.eu0_en_out, 0);
        chk("rst_en1", bus.eu1_en_out, 0);
        chk("rst_pc0", bus.eu0_pc_out, 0);
        chk("rst_rd1", bus.eu1_rd_out, 0);
        chk("rst_rdy", bus.in_ready, 1);
        #2 rstn = 1'b1;
        step();
        chk("rel_rdy", bus.in_ready, 1);

        // independent pair
        put(0, ALU, 4, 1, 2, 3'b111, 32'h100);
        put(1, ALU, 5, 3, 6, 3'b111, 32'h104);
        step();
        idle();
        step();
        chk("pair_en0", bus.eu0_en_out, 1);
        chk("pair_en1", bus.eu1_en_out, 1);
        chk("pair_pc0", bus.eu0_pc_out, 32'h100);
        chk("pair_pc1", bus.eu1_pc_out, 32'h104);
        chk("pair_rd1", bus.eu1_rd_out, 5);
        chk("pair_pcn1", bus.eu1_pc_next_out, 32'h108);
        chk("pair_imm0", bus.eu0_imm_out, 32'h155);
        wb(1, 4, 1, 5);
        step();
        wb(0, 0, 0, 0);
        chk("pair_empty0", bus.eu0_en_out, 0);
        chk("pair_empty1", bus.eu1_en_out, 0);
        chk("pair_rdy", bus.in_ready, 1);

        // intra-pair RAW on r7
        put(0, ALU, 7, 1, 0, 3'b101, 32'h200);
        put(1, ALU, 8, 7, 0, 3'b101, 32'h204);
        step();
        idle();
        step();
        chk("raw_en0", bus.eu0_en_out, 1);
        chk("raw_pc0", bus.eu0_pc_out, 32'h200);
        chk("raw_en1", bus.eu1_en_out, 0);
        step();
        chk("raw_wait", bus.eu0_en_out, 0);
        wb(0, 0, 1, 7);
        step();
        wb(0, 0, 0, 0);
        chk("raw_byp_en", bus.eu0_en_out, 1);
        chk("raw_byp_pc", bus.eu0_pc_out, 32'h204);
        chk("raw_byp_e1", bus.eu1_en_out, 0);
        wb(1, 8, 0, 0);
        step();
        wb(0, 0, 0, 0);

        // memory uop cannot go to eu1
        put(0, ALU, 9, 1, 0, 3'b101, 32'h300);
        put(1, MEM, 10, 2, 0, 3'b101, 32'h304);
        step();
        idle();
        step();
        chk("mem_en0", bus.eu0_en_out, 1);
        chk("mem_pc0", bus.eu0_pc_out, 32'h300);
        chk("mem_en1", bus.eu1_en_out, 0);
        step();
        chk("mem_en0b", bus.eu0_en_out, 1);
        chk("mem_pc0b", bus.eu0_pc_out, 32'h304);
        chk("mem_uop", bus.eu0_uop_out, MEM);
        wb(1, 9, 1, 10);
        step();
        wb(0, 0, 0, 0);

        // fill under stall, wrap, drain in order
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(0, ALU, 0, 0, 0, 0, 32'h400 + 32'(8 * i));
            put(1, ALU, 0, 0, 0, 0, 32'h404 + 32'(8 * i));
            step();
            chk("fill_rdy", bus.in_ready, 1);
            chk("fill_en", bus.eu0_en_out, 0);
        end
        idle();
        put(0, ALU, 0, 0, 0, 0, 32'h418);
        step();
        chk("full_rdy", bus.in_ready, 0);
        put(0, ALU, 0, 0, 0, 0, 32'h500);
        put(1, ALU, 0, 0, 0, 0, 32'h504);
        step();
        idle();
        chk("full_hold", bus.in_ready, 0);
        bus.stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drain_pc0", bus.eu0_pc_out, 32'h400 + 32'(8 * i));
            chk("drain_pc1", bus.eu1_pc_out, 32'h404 + 32'(8 * i));
            chk("drain_en1", bus.eu1_en_out, 1);
        end
        step();
        chk("drain_last", bus.eu0_pc_out, 32'h418);
        chk("drain_l_e1", bus.eu1_en_out, 0);
        step();
        chk("drain_done", bus.eu0_en_out, 0);
        chk("drain_rdy", bus.in_ready, 1);

        // flush with 5 queued and r3 busy
        put(0, ALU, 3, 1, 0, 3'b101, 32'h600);
        step();
        idle();
        step();
        chk("fl_prod", bus.eu0_en_out, 1);
        bus.stall = 1'b1;
        put(0, ALU, 12, 3, 0, 3'b101, 32'h610);
        put(1, ALU, 13, 0, 0, 3'b100, 32'h614);
        step();
        put(0, ALU, 14, 0, 0, 3'b100, 32'h618);
        put(1, ALU, 15, 0, 0, 3'b100, 32'h61c);
        step();
        idle();
        put(0, ALU, 16, 0, 0, 3'b100, 32'h620);
        step();
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        put(0, ALU, 17, 0, 0, 3'b100, 32'h700);
        put(1, ALU, 18, 0, 0, 3'b100, 32'h704);
        step();
        bus.flush = 1'b0;
        idle();
        chk("fl_en0", bus.eu0_en_out, 0);
        chk("fl_en1", bus.eu1_en_out, 0);
        chk("fl_rdy", bus.in_ready, 1);
        step();
        chk("fl_noenq", bus.eu0_en_out, 0);
        put(0, ALU, 11, 3, 0, 3'b101, 32'h800);
        step();
        idle();
        step();
        chk("fl_busy0", bus.eu0_en_out, 1);
        chk("fl_pc", bus.eu0_pc_out, 32'h800);
        wb(1, 11, 0, 0);
        step();
        wb(0, 0, 0, 0);

        // asynchronous reset while issuing
        put(0, ALU, 0, 0, 0, 0, 32'h900);
        put(1, ALU, 0, 0, 0, 0, 32'h904);
        step();
        idle();
        step();
        chk("ar_pre", bus.eu1_en_out, 1);
        #2 rstn = 1'b0;
        #1;
        chk("ar_en0", bus.eu0_en_out, 0);
        chk("ar_en1", bus.eu1_en_out, 0);
        chk("ar_pc0", bus.eu0_pc_out, 0);
        chk("ar_pc1", bus.eu1_pc_out, 0);
        #2 rstn = 1'b1;
        step();
        chk("ar_rdy", bus.in_ready, 1);
        chk("ar_idle", bus.eu0_en_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

In-order dual-issue buffer between decode and the register-file read stage. Accepts up to two decoded uops per cycle into a circular queue. Issues up to two per cycle to the eu0/eu1 slots of the register-file stage, gated by a 32-entry busy scoreboard for RAW/WAW hazards. eu0 takes any uop type; eu1 takes ALU-type uops only.

## Interface
- DEPTH, 8, queue entries; power of two, at least 4.
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  empty the queue, clear the scoreboard, drop outputs.
- stall  in  1  downstream hold; no issue this cycle.
- in0_valid, in1_valid  in  1 each  decode slots; in1_valid is only set when in0_valid is set.
- inN_uop  in  `WIDTH_UOP; inN_rd/rj/rk  in  5; inN_pc, inN_pc_next, inN_imm  in  32; inN_exp  in  6; inN_regmask  in  3  {wr_rd, use_rk, use_rj}.
- in_ready  out  1  high when at least two entries are free.
- write_en_0/1  in  1; write_addr_0/1  in  5  write-back ports, the same ones the register file sees.
- euN_en_out  out  1; euN_uop/rd/rj/rk/pc/pc_next/exp/imm_out  out  same widths as inputs  registered issue bundle for N = 0, 1.

## Operation
- Enqueue: an entry is written at the edge for each valid slot, provided in_ready is high. in0 goes in before in1. The tail pointer advances by 0, 1 or 2, with modulo-DEPTH wrap. If in_ready is low, the inputs are ignored.
- An entry is ready when all of these hold:
  - (!use_rj or rj==0 or !busy_eff[rj])
  - (!use_rk or rk==0 or !busy_eff[rk])
  - (!wr_rd or rd==0 or !busy_eff[rd])
- busy_eff[r] = busy[r] & ~(write_en_0 & write_addr_0==r) & ~(write_en_1 & write_addr_1==r). A same-cycle write-back unblocks the consumer because the register file bypasses it.
- Slot 0 issues when the queue is non-empty, the head is ready, !stall and !flush.
- Slot 1 issues the head+1 entry only if all of these hold:
  - slot 0 issues;
  - head+1 is valid and ready;
  - uop[`UOP_TYPE]==`ITYPE_IDX_ALU;
  - no dependency on the head entry: none of head+1's used rj, rk or written rd equals head.rd, with head.wr_rd and head.rd!=0.
- Issue is strictly in order: slot 1 never issues unless slot 0 does. The head pointer advances by the issue count.
- Scoreboard update at the edge:
  - for each issued entry with wr_rd and rd!=0, set busy[rd];
  - for each write_en_x, clear busy[write_addr_x];
  - if a set and a clear hit the same register, set wins.
- Outputs: euN_en_out is registered with the issue decision. The bundle fields load only when their slot issues; otherwise they hold their value.
- Flush, taking priority over everything except reset:
  - head = tail = count = 0 and busy = 0;
  - eu0_en_out = eu1_en_out = 0;
  - in-cycle inputs are not enqueued.
- Reset values: all pointers, count, busy, eu0_en_out and eu1_en_out are 0, and the bundle outputs are 0. in_ready is 1 after reset.

## Timing
- Input accepted at edge E0. The entry is eligible for issue in the following cycle, and euN_en_out rises after edge E1. Minimum latency is 2 cycles.
- in_ready is combinational from count: (DEPTH - count) >= 2. It does not depend on same-cycle issue.
- Simultaneous enqueue and issue update count by (enqueued - issued) in one edge.
- Full queue: in_ready = 0 and no entry is overwritten. Empty queue: euN_en_out = 0 next cycle.
- stall high: en outputs go to 0 at the next edge and the queue is unchanged. The scoreboard still clears on write-back.

## Structure
- Shared header uop.vh additions:
  - ISSUE_DEPTH default;
  - REGMASK_USE_RJ=0, REGMASK_USE_RK=1, REGMASK_WR_RD=2.
- Existing `UOP_TYPE and `ITYPE_IDX_ALU are reused.
- Sub-module scoreboard, which holds:
  - the 32-bit busy vector;
  - two set ports and two clear ports;
  - a flush input;
  - combinational busy_eff output, including the write-back bypass.
- The queue storage, pointers and issue logic stay in issue_queue.

## Test plan
- Independent pair: ALU uops writing r4 and r5, reading r1/r2 and r3/r6, enqueued together, idle scoreboard. Both eu0_en_out and eu1_en_out are high 2 cycles later, and count returns to 0.
- Intra-pair RAW: uop A writes r7; uop B reads r7. Only eu0 issues A; busy[7] = 1, and B waits. When write_en_1 = 1 with write_addr_1 = 7, B issues on eu0 in that same decision cycle.
- Non-ALU in slot 1: the head is ALU and head+1 is a memory uop. Only eu0 issues; the memory uop issues on eu0 in the next cycle.
- Fill to DEPTH with stall = 1. in_ready drops when count reaches 7 (DEPTH = 8). The tail wraps correctly after drain, and the issue order matches the enqueue order.
- Flush with 5 entries queued and busy[3] = 1, alongside valid inputs. The following cycle shows count = 0, busy = 0 and both en outputs 0. The flush-cycle inputs are not enqueued.
- Assert rstn low mid-issue, asynchronously. Outputs and en go to 0 immediately, and in_ready = 1 after release.
